mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single-port word-addressed RAM between the instruction-fetch requester (read only) and the data requester (read/write) of the MIPS core.
- Sits between the core and the RAM. It owns the RAM's address, writedata and load inputs and reads its combinational out bus.
- Each access is serialized through a small FSM.
- Arbitration gives data priority, with a starvation guard for instruction fetch and an out-of-range address check.

Parameters:
- DATA_W, 32, width of data and address buses.
- MEM_WORDS, 1001, number of valid RAM words; legal addresses are 0..MEM_WORDS-1.
- STARVE_LIMIT, 4, consecutive lost contests after which instruction fetch wins the next contest.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- i_req  in  1  instruction read request; held high until i_ready.
- i_addr  in  DATA_W  instruction word address; stable while i_req is high.
- i_ready  out  1  one-cycle completion pulse for instruction fetch.
- i_rdata  out  DATA_W  fetched word; valid when i_ready is high, held afterwards.
- d_req  in  1  data request; held high until d_ready.
- d_we  in  1  1 = write, 0 = read; stable while d_req is high.
- d_addr  in  DATA_W  data word address.
- d_wdata  in  DATA_W  write data.
- d_ready  out  1  one-cycle completion pulse for data access.
- d_rdata  out  DATA_W  read data; valid when d_ready is high, held afterwards.
- d_err  out  1  pulses with d_ready when d_addr was out of range.
- mem_address  out  DATA_W  RAM address.
- mem_writedata  out  DATA_W  RAM write data.
- mem_load  out  1  RAM write enable.
- mem_out  in  DATA_W  RAM combinational read data.

Behaviour:
- Reset (asynchronous, immediate):
  - State goes to IDLE.
  - i_ready, d_ready, d_err and mem_load go to 0.
  - i_rdata and d_rdata go to 0; latched address, data and we go to 0; starvation counter goes to 0.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - Arbitrates on the clock edge.
  - If neither requester is asking, stay in IDLE.
  - If only one is asking, grant it.
  - If both are asking, grant data unless starve_cnt == STARVE_LIMIT, in which case grant instruction.
  - On grant: latch owner, address, wdata and we (we is forced to 0 for instruction). Then go to ACCESS.
- ACCESS (exactly one cycle):
  - mem_address = latched address; mem_writedata = latched wdata.
  - mem_load = latched we AND address in range. mem_load is combinational from state and latches, and is 0 in every other state.
  - On the edge: capture mem_out into the owner's rdata register, or 0 if out of range. Set the owner's ready register, and d_err if the owner is data and the address is out of range. Go to DONE.
- DONE (one cycle):
  - Owner's ready is high. No arbitration happens in this cycle.
  - The requester drops req or presents a new request.
  - On the edge: clear ready and err, go to IDLE.
- Latency and throughput:
  - A request seen in IDLE at edge N completes with ready high during cycle N+2.
  - Peak throughput is one access per 3 cycles.
- Out-of-range (address >= MEM_WORDS):
  - A write is suppressed (mem_load stays 0); a read returns 0.
  - d_err pulses for data; an instruction fetch returns 0 with no error flag.
  - The comparison uses the full address width (unsigned).
- starve_cnt:
  - Increments, saturating at STARVE_LIMIT, on an IDLE contest where both request and data wins.
  - Clears when instruction is granted.
  - Holds otherwise.
- mem_address and mem_writedata show the latched values in all states (no X), so they are stable across the load cycle.
- Reset mid-ACCESS: mem_load drops immediately; the RAM write may or may not land (it is edge-dependent); no ready pulse follows.
- Changing req, addr or data while in ACCESS or DONE has no effect on the access in flight.

Decomposition:
- Shared package mips_mem_pkg holds:
  - the state encoding (IDLE=2'd0, ACCESS=2'd1, DONE=2'd2);
  - owner encoding (OWN_I=1'b0, OWN_D=1'b1);
  - the default MEM_WORDS and DATA_W constants.
- A natural sub-module is mem_arb_prio: the combinational grant decision plus the saturating starve_cnt register.

Test Plan:
- Reset, then i_req=1, i_addr=0 with the RAM preloaded word0=32'h1EF7BDEF: i_ready=1 in the second cycle after the grant edge, i_rdata=32'h1EF7BDEF, d_ready=0 throughout.
- d_req=1, d_we=1, d_addr=5, d_wdata=32'hCAFE0001, then a read of addr 5: mem_load is high for exactly one cycle; the read returns d_rdata=32'hCAFE0001 with d_err=0.
- i_req and d_req held high continuously (distinct addresses) with STARVE_LIMIT=4: grant order is D,D,D,D,I,D,D,D,D,I, and each ready pulse is exactly one cycle.
- d_we=1, d_addr=1001, d_wdata=32'hFFFFFFFF: mem_load never asserts, d_err=1 together with d_ready=1, d_rdata=0; word 1000 is unchanged.
- Assert reset during ACCESS of a data write: mem_load=0 in the same cycle, no d_ready pulse follows, and the FSM resumes from IDLE after release.
- i_addr changed from 3 to 7 during ACCESS: i_rdata equals mem[3].

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared encodings and default sizes for the MIPS instruction/data RAM arbiter.
package mips_mem_pkg;

  localparam int DATA_W_DEF       = 32;
  localparam int MEM_WORDS_DEF    = 1001;
  localparam int STARVE_LIMIT_DEF = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the instruction port, data port and RAM port seen by mem_arbiter.
//
// Handshake: a requester raises req and holds it, with its address/we/wdata
// stable, until ready pulses high for exactly one cycle; rdata (and d_err)
// are valid in that cycle and rdata holds its value afterwards.
interface mem_arbiter_if import mips_mem_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF
);

  logic              i_req;
  logic [DATA_W-1:0] i_addr;
  logic              i_ready;
  logic [DATA_W-1:0] i_rdata;

  logic              d_req;
  logic              d_we;
  logic [DATA_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ready;
  logic [DATA_W-1:0] d_rdata;
  logic              d_err;

  logic [DATA_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_writedata;
  logic              mem_load;
  logic [DATA_W-1:0] mem_out;

  state_t            dbg_state;

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_out,
    input  i_ready, i_rdata, d_ready, d_rdata, d_err,
    input  mem_address, mem_writedata, mem_load, dbg_state
  );

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_out,
    output i_ready, i_rdata, d_ready, d_rdata, d_err,
    output mem_address, mem_writedata, mem_load, dbg_state
  );

endinterface

// File: rtl/mem_arb_prio.sv
// Grant decision for the shared RAM: data wins a contest unless instruction
// fetch has lost STARVE_LIMIT contests in a row.
module mem_arb_prio import mips_mem_pkg::*; #(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic   clock,
  input  logic   reset,
  input  logic   arb_en,
  input  logic   i_req,
  input  logic   d_req,
  output logic   grant_valid,
  output owner_t grant_owner
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_cnt;
  logic             starved;

  assign starved = (starve_cnt == CNT_W'(STARVE_LIMIT));

  always_comb begin
    grant_valid = i_req | d_req;
    grant_owner = OWN_D;
    if (i_req && (!d_req || starved)) begin
      grant_owner = OWN_I;
    end
  end

  // Data only wins a contest while not starved, so the count saturates at the limit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (arb_en) begin
      if (i_req && (grant_owner == OWN_I)) begin
        starve_cnt <= '0;
      end else if (i_req && d_req && !starved) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises instruction-fetch and data accesses onto one single-port RAM,
// one access per IDLE -> ACCESS -> DONE round, with an address range check.
module mem_arbiter import mips_mem_pkg::*; #(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int MEM_WORDS    = MEM_WORDS_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input logic          clock,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  state_t            state;
  state_t            state_nxt;
  owner_t            owner;
  logic [DATA_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              lat_we;

  logic              i_ready_q;
  logic [DATA_W-1:0] i_rdata_q;
  logic              d_ready_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic              d_err_q;

  logic              arb_en;
  logic              grant_valid;
  owner_t            grant_owner;
  logic              in_range;
  logic              mem_load_c;

  assign arb_en   = (state == IDLE);
  assign in_range = (lat_addr < DATA_W'(MEM_WORDS));

  mem_arb_prio #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_prio (
    .clock       (clock),
    .reset       (reset),
    .arb_en      (arb_en),
    .i_req       (bus.i_req),
    .d_req       (bus.d_req),
    .grant_valid (grant_valid),
    .grant_owner (grant_owner)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // mem_load is decoded from state so an asynchronous reset drops it at once.
  always_comb begin
    state_nxt  = state;
    mem_load_c = 1'b0;
    case (state)
      IDLE: begin
        if (grant_valid) begin
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        state_nxt  = DONE;
        mem_load_c = lat_we & in_range;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      owner     <= OWN_I;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_we    <= 1'b0;
      i_ready_q <= 1'b0;
      i_rdata_q <= '0;
      d_ready_q <= 1'b0;
      d_rdata_q <= '0;
      d_err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            owner     <= grant_owner;
            lat_wdata <= bus.d_wdata;
            if (grant_owner == OWN_D) begin
              lat_addr <= bus.d_addr;
              lat_we   <= bus.d_we;
            end else begin
              lat_addr <= bus.i_addr;
              lat_we   <= 1'b0;
            end
          end
        end
        ACCESS: begin
          if (owner == OWN_D) begin
            d_ready_q <= 1'b1;
            d_rdata_q <= in_range ? bus.mem_out : '0;
            d_err_q   <= ~in_range;
          end else begin
            i_ready_q <= 1'b1;
            i_rdata_q <= in_range ? bus.mem_out : '0;
          end
        end
        DONE: begin
          i_ready_q <= 1'b0;
          d_ready_q <= 1'b0;
          d_err_q   <= 1'b0;
        end
        default: begin
          i_ready_q <= 1'b0;
          d_ready_q <= 1'b0;
          d_err_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.i_ready       = i_ready_q;
  assign bus.i_rdata       = i_rdata_q;
  assign bus.d_ready       = d_ready_q;
  assign bus.d_rdata       = d_rdata_q;
  assign bus.d_err         = d_err_q;
  assign bus.mem_address   = lat_addr;
  assign bus.mem_writedata = lat_wdata;
  assign bus.mem_load      = mem_load_c;
  assign bus.dbg_state     = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 1001-word RAM behind it.
module tb_mem_arbiter;
  import mips_mem_pkg::*;

  localparam int W     = 32;
  localparam int WORDS = 1001;

  localparam logic [W-1:0] WORD0  = 32'h1EF7_BDEF;
  localparam logic [W-1:0] WORD2  = 32'h2222_0002;
  localparam logic [W-1:0] WORD3  = 32'h3333_0003;
  localparam logic [W-1:0] WORD7  = 32'h7777_0007;
  localparam logic [W-1:0] WORD1K = 32'h5A5A_5A5A;

  logic clock;
  logic reset;
  int   n_vec;
  int   n_err;
  logic [0:0] exp_q[$];

  logic [W-1:0] ram [WORDS];

  mem_arbiter_if #(.DATA_W(W)) bus ();

  mem_arbiter #(
    .DATA_W       (W),
    .MEM_WORDS    (WORDS),
    .STARVE_LIMIT (4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // ---- clock / reset ----
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---- RAM model: out-of-range reads return a poison word ----
  assign bus.mem_out = (bus.mem_address < W'(WORDS)) ? ram[bus.mem_address[9:0]] : 32'hDEAD_BEEF;

  always @(posedge clock) begin
    if (bus.mem_load && (bus.mem_address < W'(WORDS))) begin
      ram[bus.mem_address[9:0]] <= bus.mem_writedata;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---- driver helpers ----
  task automatic idle_inputs();
    bus.i_req   = 1'b0;
    bus.i_addr  = '0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
  endtask

  // ---- tests ----
  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    n_vec++; if (bus.dbg_state !== IDLE) begin n_err++; $display("FAIL reset_state: got %0d want %0d", bus.dbg_state, IDLE); end
    n_vec++; if (bus.i_ready !== 1'b0) begin n_err++; $display("FAIL reset_i_ready: got %b want 0", bus.i_ready); end
    n_vec++; if (bus.d_ready !== 1'b0) begin n_err++; $display("FAIL reset_d_ready: got %b want 0", bus.d_ready); end
    n_vec++; if (bus.d_err !== 1'b0) begin n_err++; $display("FAIL reset_d_err: got %b want 0", bus.d_err); end
    n_vec++; if (bus.mem_load !== 1'b0) begin n_err++; $display("FAIL reset_mem_load: got %b want 0", bus.mem_load); end
    n_vec++; if (bus.i_rdata !== 32'h0) begin n_err++; $display("FAIL reset_i_rdata: got %h want 0", bus.i_rdata); end
    n_vec++; if (bus.d_rdata !== 32'h0) begin n_err++; $display("FAIL reset_d_rdata: got %h want 0", bus.d_rdata); end
    n_vec++; if (bus.mem_address !== 32'h0) begin n_err++; $display("FAIL reset_mem_address: got %h want 0", bus.mem_address); end
    reset = 1'b0;
  endtask

  task automatic test_ifetch();
    bus.i_req  = 1'b1;
    bus.i_addr = 32'd0;
    @(negedge clock);
    n_vec++; if (bus.dbg_state !== ACCESS) begin n_err++; $display("FAIL ifetch_access_state: got %0d want %0d", bus.dbg_state, ACCESS); end
    n_vec++; if (bus.i_ready !== 1'b0) begin n_err++; $display("FAIL ifetch_early_ready: got %b want 0", bus.i_ready); end
    @(negedge clock);
    n_vec++; if (bus.i_ready !== 1'b1) begin n_err++; $display("FAIL ifetch_ready: got %b want 1", bus.i_ready); end
    n_vec++; if (bus.i_rdata !== WORD0) begin n_err++; $display("FAIL ifetch_rdata: got %h want %h", bus.i_rdata, WORD0); end
    n_vec++; if (bus.d_ready !== 1'b0) begin n_err++; $display("FAIL ifetch_d_ready: got %b want 0", bus.d_ready); end
    bus.i_req = 1'b0;
    @(negedge clock);
    n_vec++; if (bus.i_ready !== 1'b0) begin n_err++; $display("FAIL ifetch_pulse_len: got %b want 0", bus.i_ready); end
    n_vec++; if (bus.i_rdata !== WORD0) begin n_err++; $display("FAIL ifetch_rdata_hold: got %h want %h", bus.i_rdata, WORD0); end
    n_vec++; if (bus.d_ready !== 1'b0) begin n_err++; $display("FAIL ifetch_d_ready_after: got %b want 0", bus.d_ready); end
  endtask

  task automatic test_write_read();
    int loads;
    bit got;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 32'd5;
    bus.d_wdata = 32'hCAFE_0001;
    loads = 0; got = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clock);
      if (bus.mem_load) loads++;
      if (bus.d_ready) got = 1;
    end
    n_vec++; if (got !== 1'b1) begin n_err++; $display("FAIL write_ready_timeout: got %b want 1", got); end
    n_vec++; if (loads !== 1) begin n_err++; $display("FAIL write_load_cycles: got %0d want 1", loads); end
    n_vec++; if (bus.d_err !== 1'b0) begin n_err++; $display("FAIL write_d_err: got %b want 0", bus.d_err); end
    bus.d_we = 1'b0;
    loads = 0; got = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clock);
      if (bus.mem_load) loads++;
      if (bus.d_ready) got = 1;
    end
    n_vec++; if (got !== 1'b1) begin n_err++; $display("FAIL read_ready_timeout: got %b want 1", got); end
    n_vec++; if (bus.d_rdata !== 32'hCAFE_0001) begin n_err++; $display("FAIL read_back: got %h want cafe0001", bus.d_rdata); end
    n_vec++; if (bus.d_err !== 1'b0) begin n_err++; $display("FAIL read_d_err: got %b want 0", bus.d_err); end
    n_vec++; if (loads !== 0) begin n_err++; $display("FAIL read_load_cycles: got %0d want 0", loads); end
    bus.d_req = 1'b0;
    @(negedge clock);
    n_vec++; if (bus.d_ready !== 1'b0) begin n_err++; $display("FAIL read_pulse_len: got %b want 0", bus.d_ready); end
  endtask

  task automatic test_starvation();
    bit prev_pulse;
    logic [0:0] exp;
    int c;
    exp_q = {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    bus.i_req  = 1'b1;
    bus.i_addr = 32'd3;
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 32'd7;
    prev_pulse = 1'b0;
    c = 0;
    while (exp_q.size() > 0 && c < 60) begin
      @(negedge clock);
      c++;
      if (bus.i_ready || bus.d_ready) begin
        exp = exp_q.pop_front();
        n_vec++; if ((bus.i_ready && bus.d_ready) || (bus.d_ready !== exp[0])) begin
          n_err++; $display("FAIL starve_grant_order: got i=%b d=%b want d=%b", bus.i_ready, bus.d_ready, exp[0]);
        end
        n_vec++; if (prev_pulse !== 1'b0) begin n_err++; $display("FAIL starve_pulse_len: got consecutive ready want single"); end
        if (exp[0]) begin
          n_vec++; if (bus.d_rdata !== WORD7) begin n_err++; $display("FAIL starve_d_rdata: got %h want %h", bus.d_rdata, WORD7); end
        end else begin
          n_vec++; if (bus.i_rdata !== WORD3) begin n_err++; $display("FAIL starve_i_rdata: got %h want %h", bus.i_rdata, WORD3); end
        end
        if (exp_q.size() == 0) begin
          bus.i_req = 1'b0;
          bus.d_req = 1'b0;
        end
        prev_pulse = 1'b1;
      end else begin
        prev_pulse = 1'b0;
      end
    end
    n_vec++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL starve_timeout: got %0d grants left want 0", exp_q.size()); end
    idle_inputs();
    @(negedge clock);
    n_vec++; if ((bus.i_ready | bus.d_ready) !== 1'b0) begin n_err++; $display("FAIL starve_last_pulse_len: got i=%b d=%b want 0", bus.i_ready, bus.d_ready); end
  endtask

  task automatic test_out_of_range();
    int loads;
    bit got;
    bit err_seen;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 32'd1001;
    bus.d_wdata = 32'hFFFF_FFFF;
    loads = 0; got = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clock);
      if (bus.mem_load) loads++;
      if (bus.d_ready) got = 1;
    end
    n_vec++; if (got !== 1'b1) begin n_err++; $display("FAIL oor_ready_timeout: got %b want 1", got); end
    n_vec++; if (loads !== 0) begin n_err++; $display("FAIL oor_mem_load: got %0d cycles want 0", loads); end
    n_vec++; if (bus.d_err !== 1'b1) begin n_err++; $display("FAIL oor_d_err: got %b want 1", bus.d_err); end
    n_vec++; if (bus.d_rdata !== 32'h0) begin n_err++; $display("FAIL oor_d_rdata: got %h want 0", bus.d_rdata); end
    bus.d_we   = 1'b0;
    bus.d_addr = 32'd1000;
    got = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clock);
      if (bus.d_ready) got = 1;
    end
    n_vec++; if (got !== 1'b1) begin n_err++; $display("FAIL top_word_timeout: got %b want 1", got); end
    n_vec++; if (bus.d_rdata !== WORD1K) begin n_err++; $display("FAIL top_word_unchanged: got %h want %h", bus.d_rdata, WORD1K); end
    n_vec++; if (bus.d_err !== 1'b0) begin n_err++; $display("FAIL top_word_d_err: got %b want 0", bus.d_err); end
    // Fetch far above the RAM: only a full-width compare rejects this one.
    bus.d_req  = 1'b0;
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h8000_0000;
    got = 0; err_seen = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clock);
      if (bus.d_err) err_seen = 1;
      if (bus.i_ready) got = 1;
    end
    n_vec++; if (got !== 1'b1) begin n_err++; $display("FAIL oor_fetch_timeout: got %b want 1", got); end
    n_vec++; if (bus.i_rdata !== 32'h0) begin n_err++; $display("FAIL oor_fetch_rdata: got %h want 0", bus.i_rdata); end
    n_vec++; if (err_seen !== 1'b0) begin n_err++; $display("FAIL oor_fetch_d_err: got %b want 0", err_seen); end
    idle_inputs();
    @(negedge clock);
  endtask

  task automatic test_reset_mid_access();
    int pulses;
    bit got;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 32'd9;
    bus.d_wdata = 32'hBAD0_0009;
    @(negedge clock);
    n_vec++; if (bus.mem_load !== 1'b1) begin n_err++; $display("FAIL rst_pre_load: got %b want 1", bus.mem_load); end
    #2;
    reset = 1'b1;
    bus.d_req = 1'b0;
    #1;
    n_vec++; if (bus.mem_load !== 1'b0) begin n_err++; $display("FAIL rst_load_drop: got %b want 0", bus.mem_load); end
    n_vec++; if (bus.dbg_state !== IDLE) begin n_err++; $display("FAIL rst_state: got %0d want %0d", bus.dbg_state, IDLE); end
    @(negedge clock);
    reset = 1'b0;
    pulses = 0;
    repeat (4) begin
      @(negedge clock);
      if (bus.d_ready || bus.i_ready) pulses++;
    end
    n_vec++; if (pulses !== 0) begin n_err++; $display("FAIL rst_no_ready: got %0d pulses want 0", pulses); end
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 32'd2;
    got = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clock);
      if (bus.d_ready) got = 1;
    end
    n_vec++; if (got !== 1'b1) begin n_err++; $display("FAIL rst_resume_timeout: got %b want 1", got); end
    n_vec++; if (bus.d_rdata !== WORD2) begin n_err++; $display("FAIL rst_resume_rdata: got %h want %h", bus.d_rdata, WORD2); end
    idle_inputs();
    @(negedge clock);
  endtask

  task automatic test_addr_change();
    bus.i_req  = 1'b1;
    bus.i_addr = 32'd3;
    @(negedge clock);
    n_vec++; if (bus.dbg_state !== ACCESS) begin n_err++; $display("FAIL chg_access_state: got %0d want %0d", bus.dbg_state, ACCESS); end
    bus.i_addr = 32'd7;
    @(negedge clock);
    n_vec++; if (bus.i_ready !== 1'b1) begin n_err++; $display("FAIL chg_ready: got %b want 1", bus.i_ready); end
    n_vec++; if (bus.i_rdata !== WORD3) begin n_err++; $display("FAIL chg_rdata: got %h want %h", bus.i_rdata, WORD3); end
    idle_inputs();
    @(negedge clock);
  endtask

  // ---- sequence and report ----
  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b0;
    for (int i = 0; i < WORDS; i++) ram[i] = 32'h0001_0000 + W'(i);
    ram[0]    = WORD0;
    ram[2]    = WORD2;
    ram[3]    = WORD3;
    ram[7]    = WORD7;
    ram[1000] = WORD1K;
    idle_inputs();

    test_reset();
    test_ifetch();
    test_write_read();
    test_starvation();
    test_out_of_range();
    test_reset_mid_access();
    test_addr_change();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
